// File: rtl/text_pkg.sv
// Shared types and constants for the 80-column text-mode writer path.
package text_pkg;

    typedef enum logic [1:0] {
        CMD_CHAR      = 2'b00,
        CMD_NEWLINE   = 2'b01,
        CMD_BACKSPACE = 2'b10,
        CMD_CLEAR     = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR
    } state_t;

    localparam int unsigned TEXT_COLS = 80;
    localparam int unsigned TEXT_ROWS = 8;

    localparam logic [4:0] CH_SPACE = 5'd0;
    localparam logic [4:0] CH_A     = 5'd1;
    localparam logic [4:0] CH_Z     = 5'd26;
    localparam logic [4:0] CH_STAR  = 5'd27;
    localparam logic [4:0] CH_HASH  = 5'd28;
    localparam logic [4:0] CH_MAX   = 5'd28;

    // Glyph codes outside the font table are rendered as blanks.
    function automatic logic [4:0] sanitize(input logic [4:0] code);
        return (code > CH_MAX) ? CH_SPACE : code;
    endfunction

endpackage

// File: rtl/text_cursor_addr.sv
// Combinational (row, col) to linear cell address, matching the renderer's col + row*COLS.
module text_cursor_addr #(
    parameter int unsigned COLS = 80,
    parameter int unsigned AW   = 10
) (
    input  logic [2:0]    row,
    input  logic [6:0]    col,
    output logic [AW-1:0] address
);

    generate
        if (COLS == 80) begin : g_shift_add
            // row*80 == row*64 + row*16
            always_comb begin
                address = (AW'(row) << 6) + (AW'(row) << 4) + AW'(col);
            end
        end else begin : g_mult
            always_comb begin
                address = AW'(row) * AW'(COLS) + AW'(col);
            end
        end
    endgenerate

endmodule

// File: rtl/text_buffer_writer.sv
// Writer side of the text-mode display: command handshake, cursor management,
// single-cell writes and full-screen clear sweeps into one of two text RAMs.
module text_buffer_writer
    import text_pkg::*;
#(
    parameter int unsigned COLS = TEXT_COLS,
    parameter int unsigned ROWS = TEXT_ROWS,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_cmd,
    input  logic [4:0]    in_char,
    input  logic          in_bank,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram1_wren,
    output logic          ram2_wren,
    output logic [6:0]    cursor_col,
    output logic [2:0]    cursor_row,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);
    localparam logic [6:0]    LAST_COL  = 7'(COLS - 1);
    localparam logic [2:0]    LAST_ROW  = 3'(ROWS - 1);

    state_t        state;
    logic          bank;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] back_addr;
    logic [6:0]    back_col;
    logic [2:0]    back_row;

    text_cursor_addr #(.COLS(COLS), .AW(AW)) u_addr (
        .row     (cursor_row),
        .col     (cursor_col),
        .address (cur_addr)
    );

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Row-major layout makes the previous cell simply address-1, clamped at the origin.
    always_comb begin
        back_col  = cursor_col;
        back_row  = cursor_row;
        back_addr = (cur_addr == '0) ? '0 : cur_addr - AW'(1);
        if (cursor_col != '0) begin
            back_col = cursor_col - 7'd1;
        end else if (cursor_row != '0) begin
            back_col = LAST_COL;
            back_row = cursor_row - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cursor_col  <= '0;
            cursor_row  <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram1_wren   <= 1'b0;
            ram2_wren   <= 1'b0;
            bank        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (cmd_t'(in_cmd))
                            CMD_CHAR: begin
                                ram_address <= cur_addr;
                                ram_data    <= DW'(sanitize(in_char));
                                ram1_wren   <= ~in_bank;
                                ram2_wren   <= in_bank;
                                bank        <= in_bank;
                                state       <= S_WRITE;
                                if (cursor_col == LAST_COL) begin
                                    cursor_col <= '0;
                                    cursor_row <= (cursor_row == LAST_ROW) ? '0 : cursor_row + 3'd1;
                                end else begin
                                    cursor_col <= cursor_col + 7'd1;
                                end
                            end
                            CMD_NEWLINE: begin
                                cursor_col <= '0;
                                cursor_row <= (cursor_row == LAST_ROW) ? '0 : cursor_row + 3'd1;
                            end
                            CMD_BACKSPACE: begin
                                ram_address <= back_addr;
                                ram_data    <= '0;
                                ram1_wren   <= ~in_bank;
                                ram2_wren   <= in_bank;
                                bank        <= in_bank;
                                cursor_col  <= back_col;
                                cursor_row  <= back_row;
                                state       <= S_WRITE;
                            end
                            CMD_CLEAR: begin
                                ram_address <= '0;
                                ram_data    <= '0;
                                ram1_wren   <= ~in_bank;
                                ram2_wren   <= in_bank;
                                bank        <= in_bank;
                                state       <= S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    ram1_wren <= 1'b0;
                    ram2_wren <= 1'b0;
                    state     <= S_IDLE;
                end
                S_CLEAR: begin
                    if (ram_address == LAST_ADDR) begin
                        ram1_wren  <= 1'b0;
                        ram2_wren  <= 1'b0;
                        cursor_col <= '0;
                        cursor_row <= '0;
                        state      <= S_IDLE;
                    end else begin
                        ram_address <= ram_address + AW'(1);
                        ram1_wren   <= ~bank;
                        ram2_wren   <= bank;
                    end
                end
                default: begin
                    ram1_wren <= 1'b0;
                    ram2_wren <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Writer side of the 80-column text-mode display path. Accepts character and cursor commands over a valid/ready handshake.
- Converts the cursor position into a cell address and drives the write port of one of the two on-chip text RAMs (bank 0 / bank 1). The VGA character renderer reads these RAMs as `address = col + row*80`.
- Manages the cursor: advance, newline, backspace and wrap-around.
- Provides a full-screen clear sweep.

Parameters:
- COLS, 80, characters per row.
- ROWS, 8, character rows; the display region is 64 px tall.
- AW, 10, RAM address width; requires COLS*ROWS <= 2**AW.
- DW, 8, RAM data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  block can accept a command this cycle
- in_cmd  in  2  00=CHAR, 01=NEWLINE, 10=BACKSPACE, 11=CLEAR
- in_char  in  5  glyph code: 0=space, 1..26=A..Z, 27='*', 28='#'
- in_bank  in  1  target RAM: 0 = ram1, 1 = ram2; latched at accept
- ram_address  out  AW  cell address written
- ram_data  out  DW  cell data, `{3'b000, code}`
- ram1_wren  out  1  write strobe for bank 0
- ram2_wren  out  1  write strobe for bank 1
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  3  current row, 0..ROWS-1
- busy  out  1  high while in WRITE or CLEAR

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; cursor=(0,0); ram_address=0, ram_data=0.
  - Both wren=0; in_ready=1; busy=0; latched bank=0.
- Handshake:
  - A command is accepted on a rising clk edge with in_valid & in_ready.
  - in_ready = (state==IDLE).
  - in_cmd, in_char and in_bank are sampled only at accept.
- Address rule: `addr = row*COLS + col`, computed at AW bits with no truncation for legal cursor values.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE, accept CHAR → WRITE.
  - Next cycle: ram_address = addr(cursor), ram_data = `{3'b000, code}`.
  - The selected bank's wren=1 for exactly 1 cycle; the other bank's wren stays 0.
  - Codes > 28 are written as 0 (space).
  - Cursor advances in the same cycle: col+1. At col = COLS-1: col=0, row+1. At (COLS-1, ROWS-1): wrap to (0,0).
  - WRITE → IDLE. Throughput is 1 CHAR per 2 cycles; write latency is 1 cycle after accept.
- IDLE, accept NEWLINE: col=0, row=row+1 (ROWS-1 wraps to 0). No RAM write; stays in IDLE.
- IDLE, accept BACKSPACE → WRITE.
  - Cursor first moves back: col-1. At col=0: col=COLS-1, row-1. At (0,0): stays at (0,0).
  - Then code 0 is written at the new position. Cursor does not advance after this write.
- IDLE, accept CLEAR → CLEAR.
  - Counter runs 0..COLS*ROWS-1, one write per cycle to the latched bank, data 0.
  - Exactly COLS*ROWS consecutive wren cycles.
  - After the last write: cursor=(0,0), → IDLE, in_ready=1 on the following cycle.
- Writes never go to both banks at once. wren is always 0 in IDLE.
- A reset mid-WRITE or mid-CLEAR aborts immediately:
  - wren drops asynchronously.
  - Cells already written keep their values; the sweep does not resume.
- ram_address and ram_data hold their last value while wren=0.

Decomposition:
- Package text_pkg:
  - enum cmd_t {CMD_CHAR, CMD_NEWLINE, CMD_BACKSPACE, CMD_CLEAR}
  - enum state_t {S_IDLE, S_WRITE, S_CLEAR}
  - constants CH_SPACE=0, CH_A=1, CH_Z=26, CH_STAR=27, CH_HASH=28, CH_MAX=28
  - constants TEXT_COLS=80, TEXT_ROWS=8
- Sub-module text_cursor_addr: combinational (row, col) → address using shift-add `(row<<6)+(row<<4)+col` for COLS=80, generic multiply otherwise. The renderer can reuse it.

Test Plan:
- Reset, then CHAR 1 (A), bank 0 → next cycle ram_address=0, ram_data=8'h01, ram1_wren=1 for 1 cycle, ram2_wren=0, cursor=(1,0), in_ready low for 1 cycle.
- Cursor at (79,0), CHAR 26 (Z) → address 79, cursor (0,1). Cursor at (79,7), CHAR 28 (#) → address 639, data 8'h1C, cursor (0,0).
- BACKSPACE at (0,1) → write address 79, data 0, cursor (79,0). BACKSPACE at (0,0) → write address 0, data 0, cursor stays (0,0).
- CLEAR with bank 1 → ram2_wren high for 640 consecutive cycles, addresses 0..639, data 0; ram1_wren=0 throughout; busy=1 for 640 cycles; then cursor (0,0), in_ready=1.
- CHAR 31 at (5,3) → data 0 written at address 245. NEWLINE at (6,3) → cursor (0,4), no wren. NEWLINE at row 7 → row 0.
- rst asserted mid-CLEAR at address 300 → wren=0 without a clock edge, cursor (0,0); after release in_ready=1 and cells 300..639 are not written.
